// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master arbiter for the shared memory/MMIO bus.
// Master 0 is the CPU and master 1 is a secondary requester. Each transaction
// is a single beat: the winner is latched in IDLE, driven onto the bus for one
// ISSUE cycle, and the bus read data is sampled in CAPTURE. The owner gets a
// one-cycle registered ack together with its registered read word.
module mem_bus_arbiter #(
  parameter int unsigned FIXED_PRIORITY = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_mask,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_mask,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  output logic [3:0]  byteMask,
  output logic        memWrite,
  input  logic [31:0] memReadData
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t      state_q, state_d;

  logic        owner_q, owner_d;
  logic        last_grant_q, last_grant_d;
  logic        is_write_q, is_write_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [31:0] mem_write_data_q, mem_write_data_d;
  logic [3:0]  byte_mask_q, byte_mask_d;
  logic        mem_write_q, mem_write_d;
  logic        m0_ack_q, m0_ack_d;
  logic        m1_ack_q, m1_ack_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;

  logic        m0_elig;
  logic        m1_elig;
  logic        grant_valid;
  logic        grant_m1;

  // A master acked this cycle still shows its old req, so it is not eligible
  // until the cycle after its ack; this keeps a stale req from a second grant.
  always_comb begin
    m0_elig     = m0_req & ~m0_ack_q;
    m1_elig     = m1_req & ~m1_ack_q;
    grant_valid = (state_q == IDLE) & (m0_elig | m1_elig);
    if (m0_elig && m1_elig) begin
      if (FIXED_PRIORITY != 0) begin
        grant_m1 = 1'b0;
      end else begin
        grant_m1 = ~last_grant_q;
      end
    end else begin
      grant_m1 = m1_elig;
    end
  end

  // State register; reset abandons any in-flight transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE waits for a grant, then ISSUE and CAPTURE run once each.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_valid) state_d = ISSUE;
      ISSUE:   state_d = CAPTURE;
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values: latch the winner in IDLE, pulse memWrite only
  // through ISSUE, and return ack plus read data to the owner out of CAPTURE.
  always_comb begin
    owner_d          = owner_q;
    last_grant_d     = last_grant_q;
    is_write_d       = is_write_q;
    mem_address_d    = mem_address_q;
    mem_write_data_d = mem_write_data_q;
    byte_mask_d      = byte_mask_q;
    mem_write_d      = 1'b0;
    m0_ack_d         = 1'b0;
    m1_ack_d         = 1'b0;
    m0_rdata_d       = m0_rdata_q;
    m1_rdata_d       = m1_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          owner_d      = grant_m1;
          last_grant_d = grant_m1;
          if (grant_m1) begin
            mem_address_d    = m1_addr;
            mem_write_data_d = m1_wdata;
            byte_mask_d      = m1_mask;
            is_write_d       = m1_we;
            mem_write_d      = m1_we;
          end else begin
            mem_address_d    = m0_addr;
            mem_write_data_d = m0_wdata;
            byte_mask_d      = m0_mask;
            is_write_d       = m0_we;
            mem_write_d      = m0_we;
          end
        end
      end
      ISSUE: begin
        mem_write_d = 1'b0;
      end
      CAPTURE: begin
        if (owner_q) begin
          m1_ack_d = 1'b1;
          if (!is_write_q) m1_rdata_d = memReadData;
        end else begin
          m0_ack_d = 1'b1;
          if (!is_write_q) m0_rdata_d = memReadData;
        end
      end
      default: begin
        mem_write_d = 1'b0;
      end
    endcase
  end

  // Datapath registers; last_grant resets to master 1 so master 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q          <= 1'b0;
      last_grant_q     <= 1'b1;
      is_write_q       <= 1'b0;
      mem_address_q    <= 32'd0;
      mem_write_data_q <= 32'd0;
      byte_mask_q      <= 4'd0;
      mem_write_q      <= 1'b0;
      m0_ack_q         <= 1'b0;
      m1_ack_q         <= 1'b0;
      m0_rdata_q       <= 32'd0;
      m1_rdata_q       <= 32'd0;
    end else begin
      owner_q          <= owner_d;
      last_grant_q     <= last_grant_d;
      is_write_q       <= is_write_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
      byte_mask_q      <= byte_mask_d;
      mem_write_q      <= mem_write_d;
      m0_ack_q         <= m0_ack_d;
      m1_ack_q         <= m1_ack_d;
      m0_rdata_q       <= m0_rdata_d;
      m1_rdata_q       <= m1_rdata_d;
    end
  end

  assign memAddress   = mem_address_q;
  assign memWriteData = mem_write_data_q;
  assign byteMask     = byte_mask_q;
  assign memWrite     = mem_write_q;
  assign m0_ack       = m0_ack_q;
  assign m1_ack       = m1_ack_q;
  assign m0_rdata     = m0_rdata_q;
  assign m1_rdata     = m1_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: one round-robin instance with a small RAM bus
// model and one fixed-priority instance with a read-only bus model. Expected
// acks (master, cycle, read word) go into a scoreboard queue when stimulus is
// driven and are popped by a monitor whenever an ack appears.
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        rstMain;
   logic        rstFp;
   logic        selFp;
   int          cyc = 0;
   int          total = 0;
   int          passed = 0;

   logic        m0Req, m0We, m1Req, m1We;
   logic [31:0] m0Addr, m0Wdata, m1Addr, m1Wdata;
   logic [3:0]  m0Mask, m1Mask;

   logic        aM0Ack, aM1Ack, aMw;
   logic [31:0] aM0Rdata, aM1Rdata, aAddr, aWdata, rdMain;
   logic [3:0]  aMask;
   logic        bM0Ack, bM1Ack, bMw;
   logic [31:0] bM0Rdata, bM1Rdata, bAddr, bWdata, rdFp;
   logic [3:0]  bMask;

   logic        obsM0Ack, obsM1Ack, obsMw;
   logic [31:0] obsM0Rdata, obsM1Rdata, obsAddr, obsWdata;
   logic [3:0]  obsMask;
   logic        prevMw = 1'b0;

   logic [31:0] mem [16];

   typedef struct {
      int          master;
      int          cyc;
      logic [31:0] rdata;
   } exp_t;
   exp_t sbq[$];

   always #5 clk = ~clk;

   // Cycle counter; a value read at a negedge names the current cycle.
   always @(posedge clk) cyc <= cyc + 1;

   mem_bus_arbiter #(.FIXED_PRIORITY(0)) dutRr (
      .clk(clk), .reset(rstMain),
      .m0_req(m0Req), .m0_we(m0We), .m0_addr(m0Addr), .m0_wdata(m0Wdata), .m0_mask(m0Mask),
      .m0_ack(aM0Ack), .m0_rdata(aM0Rdata),
      .m1_req(m1Req), .m1_we(m1We), .m1_addr(m1Addr), .m1_wdata(m1Wdata), .m1_mask(m1Mask),
      .m1_ack(aM1Ack), .m1_rdata(aM1Rdata),
      .memAddress(aAddr), .memWriteData(aWdata), .byteMask(aMask), .memWrite(aMw),
      .memReadData(rdMain)
   );

   mem_bus_arbiter #(.FIXED_PRIORITY(1)) dutFp (
      .clk(clk), .reset(rstFp),
      .m0_req(m0Req), .m0_we(m0We), .m0_addr(m0Addr), .m0_wdata(m0Wdata), .m0_mask(m0Mask),
      .m0_ack(bM0Ack), .m0_rdata(bM0Rdata),
      .m1_req(m1Req), .m1_we(m1We), .m1_addr(m1Addr), .m1_wdata(m1Wdata), .m1_mask(m1Mask),
      .m1_ack(bM1Ack), .m1_rdata(bM1Rdata),
      .memAddress(bAddr), .memWriteData(bWdata), .byteMask(bMask), .memWrite(bMw),
      .memReadData(rdFp)
   );

   assign obsM0Ack   = selFp ? bM0Ack   : aM0Ack;
   assign obsM1Ack   = selFp ? bM1Ack   : aM1Ack;
   assign obsM0Rdata = selFp ? bM0Rdata : aM0Rdata;
   assign obsM1Rdata = selFp ? bM1Rdata : aM1Rdata;
   assign obsAddr    = selFp ? bAddr    : aAddr;
   assign obsWdata   = selFp ? bWdata   : aWdata;
   assign obsMask    = selFp ? bMask    : aMask;
   assign obsMw      = selFp ? bMw      : aMw;

   // Initial RAM contents: word i holds 0xC0DE000i, except word 4 (0x10) holds 0xDEADBEEF.
   function automatic logic [31:0] memInit(input int i);
      if (i == 4) return 32'hDEADBEEF;
      return 32'hC0DE_0000 | 32'(i);
   endfunction

   // RAM bus model for the round-robin instance: masked writes, one-cycle read latency.
   always @(posedge clk) begin
      if (rstMain) begin
         for (int i = 0; i < 16; i++) mem[i] <= memInit(i);
         rdMain <= 32'd0;
      end else begin
         if (aMw) begin
            for (int b = 0; b < 4; b++)
               if (aMask[b]) mem[aAddr[5:2]][b*8 +: 8] <= aWdata[b*8 +: 8];
         end
         rdMain <= mem[aAddr[5:2]];
      end
   end

   // Read-only bus model for the fixed-priority instance.
   always @(posedge clk) rdFp <= memInit(int'(bAddr[5:2]));

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp)
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
      else
         passed++;
   endtask

   // Monitor: every ack pops one scoreboard entry; memWrite must never last two cycles.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (obsM0Ack || obsM1Ack) begin
            checkOutput("dual_ack", 32'(obsM0Ack & obsM1Ack), 32'd0);
            checkOutput("ack_expected", 32'(sbq.size() > 0), 32'd1);
            if (sbq.size() > 0) begin
               e = sbq.pop_front();
               checkOutput("ack_master", 32'(obsM1Ack), 32'(e.master));
               checkOutput("ack_cycle", 32'(cyc), 32'(e.cyc));
               checkOutput("ack_rdata", obsM1Ack ? obsM1Rdata : obsM0Rdata, e.rdata);
            end
         end
         if (obsMw) checkOutput("mw_single", 32'(prevMw), 32'd0);
         prevMw = obsMw;
      end
   end

   task automatic driveMaster(input bit sel1, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] mask);
      if (sel1) begin
         m1We = we; m1Addr = addr; m1Wdata = wdata; m1Mask = mask; m1Req = 1'b1;
      end else begin
         m0We = we; m0Addr = addr; m0Wdata = wdata; m0Mask = mask; m0Req = 1'b1;
      end
   endtask

   // One isolated transaction from a single master, checking the bus cycle by cycle.
   task automatic applyStimulus(input bit sel1, input bit we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] mask,
                                input logic [31:0] expRdata);
      int c0;
      @(negedge clk);
      driveMaster(sel1, we, addr, wdata, mask);
      c0 = cyc;
      sbq.push_back('{int'(sel1), c0 + 3, expRdata});
      checkOutput("c0_memwrite", 32'(obsMw), 32'd0);
      @(negedge clk);
      checkOutput("c1_addr", obsAddr, addr);
      checkOutput("c1_memwrite", 32'(obsMw), 32'(we));
      if (we) begin
         checkOutput("c1_wdata", obsWdata, wdata);
         checkOutput("c1_mask", 32'(obsMask), 32'(mask));
      end
      @(negedge clk);
      checkOutput("c2_addr", obsAddr, addr);
      checkOutput("c2_memwrite", 32'(obsMw), 32'd0);
      checkOutput("c2_no_ack", 32'(sel1 ? obsM1Ack : obsM0Ack), 32'd0);
      @(negedge clk);
      checkOutput("c3_ack", 32'(sel1 ? obsM1Ack : obsM0Ack), 32'd1);
      checkOutput("c3_memwrite", 32'(obsMw), 32'd0);
      if (sel1) m1Req = 1'b0; else m0Req = 1'b0;
      @(negedge clk);
      checkOutput("c4_ack_low", 32'(sel1 ? obsM1Ack : obsM0Ack), 32'd0);
   endtask

   initial begin
      int c0;
      logic [31:0] wordExp;
      rstMain = 1'b1; rstFp = 1'b1; selFp = 1'b0;
      m0Req = 0; m0We = 0; m0Addr = 0; m0Wdata = 0; m0Mask = 0;
      m1Req = 0; m1We = 0; m1Addr = 0; m1Wdata = 0; m1Mask = 0;
      repeat (3) @(negedge clk);
      checkOutput("rst_addr", aAddr, 32'd0);
      checkOutput("rst_memwrite", 32'(aMw), 32'd0);
      checkOutput("rst_acks", 32'({aM0Ack, aM1Ack}), 32'd0);
      checkOutput("rst_rdata0", aM0Rdata, 32'd0);
      rstMain = 1'b0;
      @(negedge clk);

      $display("[TB] master 0 read, then master 1 read/write/readback");
      applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF);
      applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, 32'hC0DE0008);
      applyStimulus(1'b1, 1'b1, 32'hFFFFFFF0, 32'h5, 4'b0001, 32'hC0DE0008);
      wordExp = memInit(12);
      wordExp[7:0] = 8'h05;
      applyStimulus(1'b1, 1'b0, 32'hFFFFFFF0, 32'h0, 4'hF, wordExp);

      $display("[TB] both masters continuous, round robin");
      @(negedge clk);
      driveMaster(1'b0, 1'b0, 32'h04, 32'h0, 4'hF);
      driveMaster(1'b1, 1'b0, 32'h08, 32'h0, 4'hF);
      c0 = cyc;
      sbq.push_back('{0, c0 + 3,  32'hC0DE0001});
      sbq.push_back('{1, c0 + 6,  32'hC0DE0002});
      sbq.push_back('{0, c0 + 9,  32'hC0DE0001});
      sbq.push_back('{1, c0 + 12, 32'hC0DE0002});
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k == 1 || k == 7)  checkOutput("rr_grant_m0", obsAddr, 32'h04);
         if (k == 4 || k == 10) checkOutput("rr_grant_m1", obsAddr, 32'h08);
         if (k == 9)  m0Req = 1'b0;
         if (k == 12) m1Req = 1'b0;
      end
      @(negedge clk);

      $display("[TB] master 1 requests in master 0 ack cycle");
      @(negedge clk);
      driveMaster(1'b0, 1'b0, 32'h10, 32'h0, 4'hF);
      c0 = cyc;
      sbq.push_back('{0, c0 + 3, 32'hDEADBEEF});
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k == 3) begin
            m0Req = 1'b0;
            driveMaster(1'b1, 1'b0, 32'h08, 32'h0, 4'hF);
            sbq.push_back('{1, cyc + 3, 32'hC0DE0002});
         end
         if (k == 4) checkOutput("handoff_addr", obsAddr, 32'h08);
         if (k == 6) m1Req = 1'b0;
      end
      @(negedge clk);

      $display("[TB] reset during ISSUE of a read");
      @(negedge clk);
      driveMaster(1'b0, 1'b0, 32'h10, 32'h0, 4'hF);
      @(negedge clk);
      checkOutput("pre_rst_addr", aAddr, 32'h10);
      rstMain = 1'b1;
      #1;
      checkOutput("arst_addr", aAddr, 32'd0);
      checkOutput("arst_wdata", aWdata, 32'd0);
      checkOutput("arst_mask", 32'(aMask), 32'd0);
      checkOutput("arst_memwrite", 32'(aMw), 32'd0);
      checkOutput("arst_acks", 32'({aM0Ack, aM1Ack}), 32'd0);
      checkOutput("arst_rdata0", aM0Rdata, 32'd0);
      checkOutput("arst_rdata1", aM1Rdata, 32'd0);
      m0Req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rstMain = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checkOutput("rst_no_ack", 32'({obsM0Ack, obsM1Ack}), 32'd0);
      end
      driveMaster(1'b0, 1'b0, 32'h04, 32'h0, 4'hF);
      driveMaster(1'b1, 1'b0, 32'h08, 32'h0, 4'hF);
      c0 = cyc;
      sbq.push_back('{0, c0 + 3, 32'hC0DE0001});
      sbq.push_back('{1, c0 + 6, 32'hC0DE0002});
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k == 1) checkOutput("post_rst_tie", obsAddr, 32'h04);
         if (k == 3) m0Req = 1'b0;
         if (k == 6) m1Req = 1'b0;
      end
      @(negedge clk);

      $display("[TB] fixed priority instance");
      rstMain = 1'b1;
      selFp = 1'b1;
      rstFp = 1'b0;
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 32'h04, 32'h0, 4'hF, 32'hC0DE0001);
      @(negedge clk);
      driveMaster(1'b0, 1'b0, 32'h04, 32'h0, 4'hF);
      driveMaster(1'b1, 1'b0, 32'h08, 32'h0, 4'hF);
      c0 = cyc;
      sbq.push_back('{0, c0 + 3,  32'hC0DE0001});
      sbq.push_back('{1, c0 + 6,  32'hC0DE0002});
      sbq.push_back('{0, c0 + 9,  32'hC0DE0001});
      sbq.push_back('{0, c0 + 13, 32'hC0DE0001});
      for (int k = 1; k <= 13; k++) begin
         @(negedge clk);
         if (k == 1 || k == 7 || k == 11) checkOutput("fp_grant_m0", obsAddr, 32'h04);
         if (k == 4) checkOutput("fp_grant_m1", obsAddr, 32'h08);
         if (k == 6)  m1Req = 1'b0;
         if (k == 13) m0Req = 1'b0;
      end
      repeat (3) @(negedge clk);

      checkOutput("sb_empty", 32'(sbq.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
